// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment display scanner with a write-port digit register file.
// Latency: seg/an/cur_digit are registered, one cycle behind the scan position.
// No backpressure: writes always land; hold freezes the scan. Optional macro SEG_SCAN_LZB_EN.
module seg_scan_display #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 65536,
    parameter int BLANK_CYCLES = 256,
    localparam int SEL_W       = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [SEL_W-1:0]      sel,
    input  logic [3:0]            num,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic                  hold,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEL_W-1:0]      cur_digit,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SEL_W-1:0] SCAN_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [31:0]      BLANK_LIM = 32'(BLANK_CYCLES);
    localparam logic [31:0]      NUM_LIM   = 32'(NUM_DIGITS);

    logic [3:0]       regs [NUM_DIGITS];
    logic [CNT_W-1:0] div_cnt;
    logic [SEL_W-1:0] scan;

    logic div_last;
    logic scan_last;
    logic sel_ok;
    logic lzb_blank;
    logic slot_blank;

    assign div_last  = (div_cnt == DIV_LAST);
    assign scan_last = (scan == SCAN_LAST);
    assign sel_ok    = (32'(sel) < NUM_LIM);

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

`ifdef SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] zero_from;

    // zero_from[i] is set when every digit at index i and above holds zero.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (regs[i] == 4'h0);
            zero_from[i] = all_zero;
        end
        lzb_blank = (scan != '0) && zero_from[scan];
    end
`else
    assign lzb_blank = 1'b0;
`endif

    assign slot_blank = (32'(div_cnt) < BLANK_LIM) || !digit_en[scan] || lzb_blank;

    // Digit register file; out-of-range selects are dropped, writes proceed during hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                regs[i] <= 4'h0;
            end
        end else if (write && sel_ok) begin
            regs[sel] <= num;
        end
    end

    // Slot divider and scan position; frame_tick marks the wrap back to digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            scan       <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (!hold) begin
                if (div_last) begin
                    div_cnt    <= '0;
                    scan       <= scan_last ? '0 : scan + 1'b1;
                    frame_tick <= scan_last;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    // Registered display drive built from the pre-edge scan state and register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg       <= 7'h7F;
            an        <= '1;
            cur_digit <= '0;
        end else begin
            cur_digit <= scan;
            if (slot_blank) begin
                seg <= 7'h7F;
                an  <= '1;
            end else begin
                seg <= hex_decode(regs[scan]);
                an  <= ~({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << scan);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: NUM_DIGITS=3, REFRESH_DIV=8, BLANK_CYCLES=2.
// The reference model tracks an absolute scan position and derives slot/phase arithmetically.
// Directed scenarios first, then a randomized run with occasional hold and reset.
module tb_seg_scan_display;

    localparam int ND    = 3;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int SW    = 2;
    localparam int FRAME = ND * RD;

    logic          clk = 1'b0;
    logic          reset;
    logic          write;
    logic [SW-1:0] sel;
    logic [3:0]    num;
    logic [ND-1:0] digit_en;
    logic          hold;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [SW-1:0] cur_digit;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: position within the frame and the digit values.
    int         m_pos;
    logic [3:0] m_regs [ND];

    seg_scan_display #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .sel       (sel),
        .num       (num),
        .digit_en  (digit_en),
        .hold      (hold),
        .seg       (seg),
        .an        (an),
        .cur_digit (cur_digit),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic lzb_model(input int slot);
`ifdef SEG_SCAN_LZB_EN
        logic z;
        z = 1'b1;
        for (int j = slot; j < ND; j++) z = z && (m_regs[j] == 4'h0);
        return (slot > 0) && z;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: predict outputs from pre-edge state, advance model, then compare.
    task automatic tick();
        int         slot;
        int         phase;
        logic       blank;
        logic [6:0] e_seg;
        logic [ND-1:0] e_an;
        logic [SW-1:0] e_cur;
        logic       e_ft;
        slot  = (m_pos / RD) % ND;
        phase = m_pos % RD;
        blank = (phase < BC) || !digit_en[slot] || lzb_model(slot);
        if (reset) begin
            e_seg = 7'h7F;
            e_an  = '1;
            e_cur = '0;
            e_ft  = 1'b0;
        end else begin
            e_seg = blank ? 7'h7F : hex_tab[m_regs[slot]];
            e_an  = blank ? {ND{1'b1}} : ~(ND'(1) << slot);
            e_cur = SW'(slot);
            e_ft  = !hold && ((m_pos + 1) % FRAME == 0);
        end
        @(posedge clk);
        if (reset) begin
            m_pos = 0;
            for (int i = 0; i < ND; i++) m_regs[i] = 4'h0;
        end else begin
            if (write && (int'(sel) < ND)) m_regs[sel] = num;
            if (!hold) m_pos = (m_pos + 1) % FRAME;
        end
        #1;
        checks++;
        assert (seg === e_seg) else begin
            errors++; $error("FAIL seg: got %h expected %h", seg, e_seg);
        end
        checks++;
        assert (an === e_an) else begin
            errors++; $error("FAIL an: got %b expected %b", an, e_an);
        end
        checks++;
        assert (cur_digit === e_cur) else begin
            errors++; $error("FAIL cur_digit: got %0d expected %0d", cur_digit, e_cur);
        end
        checks++;
        assert (frame_tick === e_ft) else begin
            errors++; $error("FAIL frame_tick: got %b expected %b", frame_tick, e_ft);
        end
    endtask

    // Tick until the anode pattern matches, bounded; a timeout counts as a failure.
    task automatic wait_an(input logic [ND-1:0] target, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (an === target) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            errors++; $error("FAIL %s: an never reached %b (last %b)", tag, target, an);
        end
    endtask

    task automatic check_seg(input logic [6:0] exp_seg, input string tag);
        checks++;
        assert (seg === exp_seg) else begin
            errors++; $error("FAIL %s: seg got %h expected %h", tag, seg, exp_seg);
        end
    endtask

    initial begin
        int cnt;
        m_pos    = 0;
        for (int i = 0; i < ND; i++) m_regs[i] = 4'h0;
        reset    = 1'b1;
        write    = 1'b0;
        sel      = '0;
        num      = 4'h0;
        digit_en = 3'b111;
        hold     = 1'b0;

        // Reset state
        repeat (3) tick();
        check_seg(7'h7F, "reset_seg");

        // Scan after release: first BC outputs blank, then digit 0 lit
        reset = 1'b0;
        repeat (FRAME + 4) tick();

        // Write / decode
        write = 1'b1; sel = 2'd1; num = 4'hA; tick();
        sel = 2'd2; num = 4'h8; tick();
        write = 1'b0;
        wait_an(3'b101, "dig1_active");
        check_seg(7'h08, "dig1_A");
        wait_an(3'b011, "dig2_active");
        check_seg(7'h00, "dig2_8");
        wait_an(3'b110, "dig0_active");
        check_seg(7'h40, "dig0_0");

        // Out-of-range write is dropped
        write = 1'b1; sel = 2'd3; num = 4'h5; tick();
        write = 1'b0;
        wait_an(3'b110, "dig0_after_oob");
        check_seg(7'h40, "oob_dig0");

        // Digit 1 disabled for a full frame
        digit_en = 3'b101;
        cnt = 0;
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            if (an === 3'b101) cnt++;
        end
        checks++;
        assert (cnt == 0) else begin
            errors++; $error("FAIL dig1_blank: lit %0d cycles expected 0", cnt);
        end
        digit_en = 3'b111;

        // Hold mid-slot of digit 1, with a write during hold
        wait_an(3'b101, "hold_entry");
        tick();
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin write = 1'b1; sel = 2'd1; num = 4'h3; end
            else write = 1'b0;
            tick();
            checks++;
            assert (cur_digit === 2'd1 && frame_tick === 1'b0) else begin
                errors++; $error("FAIL hold: cur_digit %0d ft %b expected 1/0", cur_digit, frame_tick);
            end
            if (i == 11) check_seg(7'h30, "hold_write");
        end
        hold = 1'b0;
        write = 1'b0;
        repeat (4) tick();

        // Reset mid-frame while digit 2 is shown
        wait_an(3'b011, "pre_reset_dig2");
        reset = 1'b1;
        tick();
        check_seg(7'h7F, "midreset_seg");
        checks++;
        assert (an === 3'b111) else begin
            errors++; $error("FAIL midreset_an: got %b expected 111", an);
        end
        reset = 1'b0;
        tick();
        checks++;
        assert (cur_digit === 2'd0) else begin
            errors++; $error("FAIL restart: cur_digit got %0d expected 0", cur_digit);
        end
        wait_an(3'b101, "dig1_after_reset");
        check_seg(7'h40, "regs_cleared");

        // Leading-zero case: regs {0,0,5}
        write = 1'b1; sel = 2'd0; num = 4'h5; tick();
        write = 1'b0;
`ifdef SEG_SCAN_LZB_EN
        cnt = 0;
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            if (an === 3'b101 || an === 3'b011) cnt++;
        end
        checks++;
        assert (cnt == 0) else begin
            errors++; $error("FAIL lzb: upper digits lit %0d cycles expected 0", cnt);
        end
`else
        wait_an(3'b101, "nolzb_dig1");
        check_seg(7'h40, "nolzb_dig1_0");
        wait_an(3'b011, "nolzb_dig2");
        check_seg(7'h40, "nolzb_dig2_0");
`endif
        wait_an(3'b110, "lzb_dig0");
        check_seg(7'h12, "dig0_5");

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            write = 1'($urandom_range(0, 1));
            sel   = SW'($urandom_range(0, 3));
            num   = 4'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en = ND'($urandom);
            hold  = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
